// File: rtl/led_pattern_gen_pkg.sv
// Shared mode encodings for the LED pattern generator and anything that
// drives its mode input (switch decoder, debug register).
package led_pattern_gen_pkg;

  typedef enum logic [1:0] {
    MODE_COUNT   = 2'd0,
    MODE_SCAN    = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_BLINK   = 2'd3
  } mode_e;

endpackage

// File: rtl/led_pattern_gen_tick_gen.sv
// Reusable prescaler: counts 0..DIV-1 while en is high and flags the cycle
// whose clock edge wraps the count back to zero.
module tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Combinational so the consumer can register its step result on the wrap edge.
  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: COUNT, SCAN, BREATHE and BLINK patterns paced by a
// prescaler, with a pause input and a runtime mode load.
module led_pattern_gen
  import led_pattern_gen_pkg::*;
#(
  parameter int NUM_LEDS = 8,
  parameter int RATE_DIV = 6250000,
  parameter int PWM_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          mode,
  input  logic                mode_valid,
  input  logic                pause,
  output logic [NUM_LEDS-1:0] led,
  output logic                step_tick,
  output logic [1:0]          mode_q
);

  localparam logic [NUM_LEDS-1:0] SCAN_INIT = {{(NUM_LEDS-1){1'b0}}, 1'b1};
  localparam logic [PWM_W-1:0]    DUTY_MAX  = '1;

  logic tick;
  logic step;

  mode_e               mode_r, mode_n;
  logic [NUM_LEDS-1:0] count_r, count_n;
  logic [NUM_LEDS-1:0] scan_r, scan_n;
  logic                scan_up_r, scan_up_n;
  logic [PWM_W-1:0]    duty_r, duty_n;
  logic                duty_up_r, duty_up_n;
  logic                blink_r, blink_n;
  logic [PWM_W-1:0]    pwm_cnt;
  logic [NUM_LEDS-1:0] led_n;

  tick_gen #(.DIV(RATE_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (mode_valid),
    .en   (~pause),
    .tick (tick)
  );

  // mode_valid is a one-cycle load strobe with no ready: every edge on which
  // it is high restarts the requested mode, overriding any coincident step.
  assign step   = tick && !mode_valid;
  assign mode_q = mode_r;

  always_comb begin
    mode_n    = mode_r;
    count_n   = count_r;
    scan_n    = scan_r;
    scan_up_n = scan_up_r;
    duty_n    = duty_r;
    duty_up_n = duty_up_r;
    blink_n   = blink_r;

    if (mode_valid) begin
      mode_n    = mode_e'(mode);
      count_n   = '0;
      scan_n    = SCAN_INIT;
      scan_up_n = 1'b1;
      duty_n    = '0;
      duty_up_n = 1'b1;
      blink_n   = 1'b0;
    end else if (step) begin
      case (mode_r)
        MODE_COUNT: count_n = count_r + 1'b1;
        MODE_SCAN: begin
          // Reverse at an endpoint on the same step, so ends are lit once.
          if (scan_up_r) begin
            if (scan_r[NUM_LEDS-1]) begin
              scan_n    = scan_r >> 1;
              scan_up_n = 1'b0;
            end else begin
              scan_n = scan_r << 1;
            end
          end else begin
            if (scan_r[0]) begin
              scan_n    = scan_r << 1;
              scan_up_n = 1'b1;
            end else begin
              scan_n = scan_r >> 1;
            end
          end
        end
        MODE_BREATHE: begin
          if (duty_up_r) begin
            if (duty_r == DUTY_MAX) begin
              duty_n    = duty_r - 1'b1;
              duty_up_n = 1'b0;
            end else begin
              duty_n = duty_r + 1'b1;
            end
          end else begin
            if (duty_r == '0) begin
              duty_n    = duty_r + 1'b1;
              duty_up_n = 1'b1;
            end else begin
              duty_n = duty_r - 1'b1;
            end
          end
        end
        default: blink_n = ~blink_r;
      endcase
    end

    case (mode_n)
      MODE_COUNT:   led_n = count_n;
      MODE_SCAN:    led_n = scan_n;
      MODE_BREATHE: led_n = {NUM_LEDS{pwm_cnt < duty_n}};
      default:      led_n = {NUM_LEDS{blink_n}};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_r    <= MODE_COUNT;
      count_r   <= '0;
      scan_r    <= SCAN_INIT;
      scan_up_r <= 1'b1;
      duty_r    <= '0;
      duty_up_r <= 1'b1;
      blink_r   <= 1'b0;
      pwm_cnt   <= '0;
      led       <= '0;
      step_tick <= 1'b0;
    end else begin
      mode_r    <= mode_n;
      count_r   <= count_n;
      scan_r    <= scan_n;
      scan_up_r <= scan_up_n;
      duty_r    <= duty_n;
      duty_up_r <= duty_up_n;
      blink_r   <= blink_n;
      pwm_cnt   <= pwm_cnt + 1'b1;
      led       <= led_n;
      step_tick <= step;
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: a step-level reference model queues each
// expected step (edge number, mode, led) and a monitor checks every step_tick.
module tb_led_pattern_gen;

  localparam int N   = 8;
  localparam int DIV = 4;
  localparam int PW  = 4;
  localparam int EW  = 42;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   mode;
  logic         mode_valid;
  logic         pause;
  logic [N-1:0] led;
  logic         step_tick;
  logic [1:0]   mode_q;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int m_mode = 0;
  int m_p    = 0;
  int m_k    = 0;

  logic [EW-1:0] exp_q[$];

  always #5 clk = ~clk;

  led_pattern_gen #(.NUM_LEDS(N), .RATE_DIV(DIV), .PWM_W(PW)) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .mode_valid (mode_valid),
    .pause      (pause),
    .led        (led),
    .step_tick  (step_tick),
    .mode_q     (mode_q)
  );

  // Value of a 0..top..0 triangle wave after k steps, ends visited once.
  function automatic int bounce(input int k, input int top);
    int per;
    int pos;
    per = 2 * top;
    pos = k % per;
    return (pos > top) ? per - pos : pos;
  endfunction

  function automatic logic [N-1:0] pat(input int m, input int k);
    logic [N-1:0] one;
    one = 1;
    case (m)
      0:       return N'(k);
      1:       return one << bounce(k, N - 1);
      3:       return (k % 2 == 1) ? '1 : '0;
      default: return '0;
    endcase
  endfunction

  function automatic int duty_of(input int k);
    return bounce(k, (1 << PW) - 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at edge %0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: spec-level prescaler, mode and step index.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_mode = 0;
      m_p    = 0;
      m_k    = 0;
      exp_q.delete();
    end else if (mode_valid) begin
      m_mode = int'(mode);
      m_p    = 0;
      m_k    = 0;
    end else if (!pause) begin
      if (m_p == DIV - 1) begin
        m_p = 0;
        m_k++;
        exp_q.push_back({32'(cyc), 2'(m_mode), pat(m_mode, m_k)});
      end else begin
        m_p++;
      end
    end
  end

  // Monitor: every step_tick must match the oldest expected step.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (step_tick === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_step actual=1 expected=0 at edge %0d", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("step_edge", 32'(cyc), e[41:10]);
        if (e[9:8] != 2'd2) chk("step_led", 32'(led), 32'(e[7:0]));
      end
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_step actual=0 expected=1 at edge %0d (due %0d)", cyc, e[41:10]);
    end
  end

  task automatic wait_steps(input int n);
    int seen;
    int budget;
    seen   = 0;
    budget = n * DIV * 4 + 20;
    while (seen < n && budget > 0) begin
      @(negedge clk);
      if (step_tick === 1'b1) seen++;
      budget--;
    end
    chk("wait_steps", 32'(seen), 32'(n));
  endtask

  task automatic load_mode(input logic [1:0] m);
    logic [N-1:0] init;
    init = (m == 2'd1) ? N'(1) : '0;
    mode       = m;
    mode_valid = 1'b1;
    @(negedge clk);
    mode_valid = 1'b0;
    chk("load_mode_q", 32'(mode_q), 32'(m));
    chk("load_led", 32'(led), 32'(init));
    chk("load_step_tick", 32'(step_tick), 32'd0);
  endtask

  task automatic breathe_hold(input int target);
    int hi;
    int budget;
    budget = 400;
    while (m_k != target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("breathe_reach", 32'(m_k), 32'(target));
    pause = 1'b1;
    hi    = 0;
    repeat (16) begin
      @(negedge clk);
      if (led[0]) hi++;
      chk("breathe_uniform", 32'(led == '0 || led == '1), 32'd1);
      chk("pause_no_step", 32'(step_tick), 32'd0);
    end
    chk("breathe_duty", 32'(hi), 32'(duty_of(target)));
    pause = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout actual=running expected=finished");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    int targets[9];
    int budget;
    targets = '{0, 3, 7, 15, 16, 22, 29, 31, 0};
    targets[8] = 32 + $urandom_range(0, 20);

    rst        = 1'b1;
    mode       = 2'd0;
    mode_valid = 1'b0;
    pause      = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_led", 32'(led), 32'd0);
    chk("reset_step_tick", 32'(step_tick), 32'd0);
    chk("reset_mode_q", 32'(mode_q), 32'd0);

    // COUNT: first step on the 4th edge after reset release, then wrap.
    rst = 1'b0;
    repeat (DIV - 1) begin
      @(negedge clk);
      chk("first_step_early", 32'(step_tick), 32'd0);
    end
    @(negedge clk);
    chk("first_step_tick", 32'(step_tick), 32'd1);
    chk("first_step_led", 32'(led), 32'd1);
    wait_steps((1 << N) + 1);

    load_mode(2'd1);
    wait_steps(16);

    load_mode(2'd2);
    foreach (targets[i]) breathe_hold(targets[i]);

    load_mode(2'd3);
    wait_steps(6);

    // Load coincident with a prescaler wrap.
    budget = 2 * DIV;
    while (m_p != DIV - 1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("align_wrap", 32'(m_p), 32'(DIV - 1));
    load_mode(2'd1);
    repeat (DIV - 1) begin
      @(negedge clk);
      chk("post_load_early", 32'(step_tick), 32'd0);
    end
    @(negedge clk);
    chk("post_load_step", 32'(step_tick), 32'd1);
    chk("post_load_led", 32'(led), 32'h02);

    // Reset mid-SCAN wins over a coincident load and pause.
    wait_steps(3);
    rst        = 1'b1;
    mode_valid = 1'b1;
    mode       = 2'd3;
    pause      = 1'b1;
    @(negedge clk);
    chk("rst_mode_q", 32'(mode_q), 32'd0);
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_step_tick", 32'(step_tick), 32'd0);
    rst        = 1'b0;
    mode_valid = 1'b0;
    pause      = 1'b0;
    wait_steps(3);

    // Random loads and pauses; the monitor checks every step.
    repeat (800) begin
      mode_valid = ($urandom_range(0, 19) == 0);
      mode       = 2'($urandom_range(0, 3));
      pause      = ($urandom_range(0, 7) == 0);
      @(negedge clk);
    end
    mode_valid = 1'b0;
    pause      = 1'b0;
    repeat (2 * DIV) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
